demux_1into2_stream: RTL
========================

# demux_1into2_stream

Registered 1-to-2 demultiplexer with valid/ready handshakes: the inverse of the 2:1 select mux used in the carry-select adder/subtractor datapath. Each accepted input beat is steered by `select_line` to output A (`select_line=1`) or output B (`select_line=0`), matching the mux polarity. Each output has its own 2-entry buffer, so one stalled sink does not corrupt the other. Per-output delivered-beat counters support debug and verification.

## Interface
Parameters:
- `WIDTH`, 8: payload width in bits.
- `CNT_W`, 16: width of the delivered-beat counters.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_data`, input, WIDTH: payload.
- `select_line`, input, 1: route; 1 sends to A, 0 sends to B. Sampled with `in_data`.
- `in_valid`, input, 1: input beat present.
- `in_ready`, output, 1: block can accept a beat.
- `out_a_data`, output, WIDTH: A-side payload (head of A buffer).
- `out_a_valid`, output, 1: A-side beat present.
- `out_a_ready`, input, 1: A sink accepts.
- `out_b_data`, output, WIDTH: B-side payload.
- `out_b_valid`, output, 1: B-side beat present.
- `out_b_ready`, input, 1: B sink accepts.
- `beats_a`, output, CNT_W: count of beats delivered on A; wraps.
- `beats_b`, output, CNT_W: count of beats delivered on B; wraps.

## Operation
- Input transfer occurs when `in_valid && in_ready`. The beat `{in_data}` is pushed into buffer A if `select_line=1`, otherwise into buffer B.
- `in_ready = !rst && (occ_a < 2) && (occ_b < 2)`.
  - Depends only on buffer occupancy, never on `in_data`, `select_line` or `in_valid`.
  - Deasserts if either buffer is full. This is deliberate: it keeps the ready path independent of the payload.
- Output transfers:
  - A transfer occurs on `out_x_valid && out_x_ready`, which pops the head of buffer x.
  - `out_x_valid = (occ_x != 0)`.
  - `out_x_data` = the head entry when `out_x_valid` is high. It holds its last value when the buffer is empty; the value is 0 after reset.
- Each buffer is an in-order 2-entry FIFO:
  - Push only: occupancy +1.
  - Pop only: occupancy −1.
  - Push and pop in the same cycle: occupancy unchanged. The head advances and the new beat goes behind it. At occupancy 1 the new beat becomes the head next cycle.
  - Push while full cannot occur, because `in_ready` is low.
- A valid output must hold `out_x_data` stable until its transfer completes.
- `beats_x` increments by 1 on each output-x transfer and wraps from 2^CNT_W−1 to 0.
- Reset, including reset asserted mid-stream: both buffers are emptied and all buffered beats are discarded.
  - `out_a_valid`, `out_b_valid`, `in_ready` = 0.
  - `out_a_data`, `out_b_data` = 0.
  - `beats_a`, `beats_b` = 0.
  - Input and output handshakes during a reset cycle are ignored.

## Timing
- Latency: a beat accepted at edge N is visible on `out_x_valid`/`out_x_data` after edge N (1 cycle). There is no combinational path from input to output.
- Throughput: 1 beat/cycle sustained on either or both outputs when the sinks are always ready, including alternating selects.
- `in_ready` is combinational from occupancy registers only. It goes high the cycle after `rst` deasserts.
- A buffer that is full at edge N and popped at edge N reports `in_ready=1` in cycle N+1 (provided the other buffer is not full).

## Structure
- Shared package `csa_pkg`:
  - route constants `SEL_A = 1'b1` and `SEL_B = 1'b0`;
  - default `WIDTH`/`CNT_W` localparams shared with the adder/subtractor blocks.
- Sub-module `stream_buf2`:
  - parameterized 2-entry FIFO with push, pop, `head_data`, occupancy, `full` and `empty`, plus synchronous active-high reset;
  - instantiated once per output.
- The top level contains only the steering logic, `in_ready`, and the two counters.

## Test plan
- Reset then idle:
  - hold `rst=1` for 3 cycles with `in_valid=1` → `in_ready=0`, both valids 0, data 0, counters 0;
  - the first cycle after release → `in_ready=1`.
- Alternating stream, both sinks ready:
  - send 0x11 (sel 1), 0x22 (sel 0), 0x33 (sel 1), 0x44 (sel 0) on consecutive cycles;
  - → A emits 0x11, 0x33 and B emits 0x22, 0x44, each 1 cycle after acceptance;
  - → `beats_a=2`, `beats_b=2`, no stall.
- Backpressure on A:
  - `out_a_ready=0`; send 0xA1, 0xA2, 0xA3 all sel 1;
  - → `in_ready` drops after 0xA2 is accepted;
  - → raising `out_a_ready` releases 0xA1 then 0xA2 in order;
  - → 0xA3 is accepted the cycle after the first pop.
- Simultaneous push/pop at occupancy 1:
  - A holds 0x55 while 0x66 (sel 1) is pushed with `out_a_ready=1`;
  - → 0x55 delivered, occupancy stays 1, 0x66 is the head next cycle.
- Counter wrap:
  - with `CNT_W=4`, deliver 17 beats on B → `beats_b=1`, `beats_a=0`.
- Reset mid-operation:
  - both buffers full (A: 0x01, 0x02; B: 0x03, 0x04), assert `rst` 1 cycle;
  - → all valids 0, counters 0, and no stale beat is ever emitted afterward.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared constants for the carry-select adder/subtractor datapath and the
// stream blocks that sit next to it.
package csa_pkg;

  // Route encoding, identical to the 2:1 select mux polarity.
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  // Default widths shared with the adder/subtractor blocks.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // Buffer depth used by the stream buffers.
  localparam int BUF_DEPTH = 2;

  // Occupancy encoding width for a 2-entry buffer (0, 1 or 2).
  typedef logic [1:0] occ_t;

  // True when an occupancy value leaves room for another beat.
  function automatic logic has_room(input occ_t occ);
    return (occ < occ_t'(BUF_DEPTH));
  endfunction

endpackage

// File: rtl/demux_1into2_stream_buf2.sv
// stream_buf2: in-order 2-entry FIFO built as a head register plus one tail
// register. The head register is the output, so head_data keeps its last
// value after the buffer drains and is 0 after reset.
module stream_buf2
  import csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output occ_t             occupancy,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] tail_reg, tail_next;
  occ_t             occ_reg, occ_next;
  logic             do_push;
  logic             do_pop;

  // Push into a full buffer or pop from an empty one is discarded.
  assign do_push = push && has_room(occ_reg);
  assign do_pop  = pop && (occ_reg != 2'd0);

  // Next-state: shift the tail forward on pop, place the new beat behind the head.
  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = occ_reg;
    case ({do_push, do_pop})
      2'b10: begin
        if (occ_reg == 2'd0) head_next = push_data;
        else                 tail_next = push_data;
        occ_next = occ_reg + 2'd1;
      end
      2'b01: begin
        // At occupancy 1 the head is simply left in place (holds last value).
        if (occ_reg == 2'd2) head_next = tail_reg;
        occ_next = occ_reg - 2'd1;
      end
      2'b11: begin
        if (occ_reg == 2'd1) begin
          head_next = push_data;
        end else begin
          head_next = tail_reg;
          tail_next = push_data;
        end
      end
      default: ;
    endcase
  end

  // State registers, cleared on reset so stale beats are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= 2'd0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      occ_reg  <= occ_next;
    end
  end

  assign head_data = head_reg;
  assign occupancy = occ_reg;
  assign full      = !has_room(occ_reg);
  assign empty     = (occ_reg == 2'd0);

endmodule

// File: rtl/demux_1into2_stream.sv
// demux_1into2_stream: registered 1-to-2 stream demultiplexer. Each accepted
// beat goes to A (select_line=1) or B (select_line=0) through its own
// 2-entry buffer; per-output counters track delivered beats.
// Channel index 1 is output A, index 0 is output B (matches the select value).
module demux_1into2_stream
  import csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select_line,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [CNT_W-1:0] beats_a,
  output logic [CNT_W-1:0] beats_b
);

  logic [1:0]       full_w;
  logic [1:0]       empty_w;
  logic [1:0]       push_w;
  logic [1:0]       pop_w;
  logic [1:0]       ready_w;
  occ_t             occ_w  [2];
  logic [WIDTH-1:0] head_w [2];
  logic             accept;

  // Ready depends on occupancy only, never on the payload or route.
  assign in_ready = !rst && !full_w[0] && !full_w[1];
  assign accept   = in_valid && in_ready;
  assign ready_w  = {out_a_ready, out_b_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      localparam logic ROUTE = (gi == 1) ? SEL_A : SEL_B;

      logic [CNT_W-1:0] cnt_reg;

      assign push_w[gi] = accept && (select_line == ROUTE);
      assign pop_w[gi]  = !rst && !empty_w[gi] && ready_w[gi];

      stream_buf2 #(
        .WIDTH(WIDTH)
      ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push_w[gi]),
        .push_data(in_data),
        .pop      (pop_w[gi]),
        .head_data(head_w[gi]),
        .occupancy(occ_w[gi]),
        .full     (full_w[gi]),
        .empty    (empty_w[gi])
      );

      // Delivered-beat counter; wraps naturally at 2^CNT_W.
      always_ff @(posedge clk) begin
        if (rst) cnt_reg <= '0;
        else if (pop_w[gi]) cnt_reg <= cnt_reg + 1'b1;
      end
    end
  endgenerate

  assign out_a_data  = head_w[1];
  assign out_a_valid = (occ_w[1] != 2'd0);
  assign out_b_data  = head_w[0];
  assign out_b_valid = (occ_w[0] != 2'd0);
  assign beats_a     = g_chan[1].cnt_reg;
  assign beats_b     = g_chan[0].cnt_reg;

endmodule
